// File: rtl/udp_tx_pkg.sv
// ============================================================================
// udp_tx_pkg : shared state encoding, default geometry and counter sizing
// Rev 1.0
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

package udp_tx_pkg;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_ARM     = 3'd1,
        S_START   = 3'd2,
        S_WAIT_TX = 3'd3,
        S_BUSY    = 3'd4,
        S_GAP     = 3'd5
    } sched_state_t;

    localparam int PKT_WORDS_DEF     = 98;
    localparam int FIFO_AW_DEF       = 12;
    localparam int GAP_CYCLES_DEF    = 16;
    localparam int START_TIMEOUT_DEF = 64;

    localparam int GAP_CNT_W = (GAP_CYCLES_DEF < 1) ? 1 : $clog2(GAP_CYCLES_DEF + 1);
    localparam int TO_CNT_W  = $clog2(START_TIMEOUT_DEF + 1);

    // Width of a single shared timer that can reach both terminal counts.
    function automatic int timer_width(input int gap_cycles, input int start_timeout);
        int g;
        int t;
        int w;
        g = $clog2(gap_cycles + 1);
        t = $clog2(start_timeout + 1);
        w = (g > t) ? g : t;
        return (w < 1) ? 1 : w;
    endfunction

endpackage

`default_nettype wire

// File: rtl/udp_edge_det.sv
// ============================================================================
// udp_edge_det : registered previous-value rise/fall detector
// Rev 1.0
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module udp_edge_det (
    input  logic GMII_GTXCLK,
    input  logic rst_n,
    input  logic d,
    output logic rise,
    output logic fall
);

    logic d_q;

    always_ff @(posedge GMII_GTXCLK or negedge rst_n) begin
        if (!rst_n) begin
            d_q <= 1'b0;
        end else begin
            d_q <= d;
        end
    end

    assign rise = d & ~d_q;
    assign fall = ~d & d_q;

endmodule

`default_nettype wire

// File: rtl/udp_tx_scheduler.sv
// ============================================================================
// udp_tx_scheduler : paces GMII UDP sender starts from FIFO fill level and TXEN
// Rev 1.0 -- optional counters enabled by defining UDP_SCHED_STATS_EN
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module udp_tx_scheduler
    import udp_tx_pkg::*;
#(
    parameter int PKT_WORDS     = PKT_WORDS_DEF,
    parameter int FIFO_AW       = FIFO_AW_DEF,
    parameter int GAP_CYCLES    = GAP_CYCLES_DEF,
    parameter int START_TIMEOUT = START_TIMEOUT_DEF
) (
    input  logic               GMII_GTXCLK,
    input  logic               rst_n,
    input  logic               sched_en,
    input  logic [FIFO_AW-1:0] fifo_count,
    input  logic               tx_active,
    output logic               send_start,
    output logic               sched_busy,
    output logic               timeout_err,
    output logic [31:0]        pkt_sent
`ifdef UDP_SCHED_STATS_EN
    ,
    output logic [31:0]        stall_cycles,
    output logic [15:0]        timeout_cnt
`endif
);

    localparam int TMR_W = timer_width(GAP_CYCLES, START_TIMEOUT);
    localparam logic [FIFO_AW-1:0] PKT_THRESH = FIFO_AW'(PKT_WORDS);
    // A zero gap still spends one cycle in S_GAP, so both terminals clamp at 0.
    localparam logic [TMR_W-1:0] GAP_LAST = TMR_W'((GAP_CYCLES < 1) ? 0 : GAP_CYCLES - 1);
    localparam logic [TMR_W-1:0] TO_LAST  = TMR_W'((START_TIMEOUT < 1) ? 0 : START_TIMEOUT - 1);

    sched_state_t     state;
    sched_state_t     state_nxt;
    logic [TMR_W-1:0] timer;
    logic             tx_rise;
    logic             tx_fall;
    logic             en_rise;
    logic             unused_en_fall;
    logic             fifo_ok;
    logic             start_abort;
    logic             pkt_done;

    udp_edge_det u_tx_edge (
        .GMII_GTXCLK (GMII_GTXCLK),
        .rst_n       (rst_n),
        .d           (tx_active),
        .rise        (tx_rise),
        .fall        (tx_fall)
    );

    udp_edge_det u_en_edge (
        .GMII_GTXCLK (GMII_GTXCLK),
        .rst_n       (rst_n),
        .d           (sched_en),
        .rise        (en_rise),
        .fall        (unused_en_fall)
    );

    assign fifo_ok = (fifo_count >= PKT_THRESH);

    always_ff @(posedge GMII_GTXCLK or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        start_abort = 1'b0;
        pkt_done    = 1'b0;
        case (state)
            S_IDLE: begin
                if (sched_en) begin
                    state_nxt = S_ARM;
                end
            end
            S_ARM: begin
                // Disable wins over a ready FIFO: no new packet once sched_en drops.
                if (!sched_en) begin
                    state_nxt = S_IDLE;
                end else if (fifo_ok) begin
                    state_nxt = S_START;
                end
            end
            S_START: begin
                state_nxt = S_WAIT_TX;
            end
            S_WAIT_TX: begin
                if (tx_rise) begin
                    state_nxt = S_BUSY;
                end else if (timer == TO_LAST) begin
                    start_abort = 1'b1;
                    state_nxt   = S_GAP;
                end
            end
            S_BUSY: begin
                if (tx_fall) begin
                    pkt_done  = 1'b1;
                    state_nxt = S_GAP;
                end
            end
            S_GAP: begin
                if (timer == GAP_LAST) begin
                    state_nxt = sched_en ? S_ARM : S_IDLE;
                end
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    // Shared timer: restarts on every state change, runs only where it is consumed.
    always_ff @(posedge GMII_GTXCLK or negedge rst_n) begin
        if (!rst_n) begin
            timer <= '0;
        end else if (state_nxt != state) begin
            timer <= '0;
        end else if (state == S_WAIT_TX || state == S_GAP) begin
            timer <= timer + 1'b1;
        end
    end

    always_ff @(posedge GMII_GTXCLK or negedge rst_n) begin
        if (!rst_n) begin
            timeout_err <= 1'b0;
            pkt_sent    <= '0;
        end else begin
            if (start_abort) begin
                timeout_err <= 1'b1;
            end else if (en_rise) begin
                timeout_err <= 1'b0;
            end
            if (pkt_done) begin
                pkt_sent <= pkt_sent + 32'd1;
            end
        end
    end

    assign send_start = (state == S_START);
    assign sched_busy = (state != S_IDLE);

`ifdef UDP_SCHED_STATS_EN
    always_ff @(posedge GMII_GTXCLK or negedge rst_n) begin
        if (!rst_n) begin
            stall_cycles <= '0;
            timeout_cnt  <= '0;
        end else begin
            if (state == S_ARM && sched_en && !fifo_ok) begin
                stall_cycles <= stall_cycles + 32'd1;
            end
            if (start_abort && timeout_cnt != 16'hFFFF) begin
                timeout_cnt <= timeout_cnt + 16'd1;
            end
        end
    end
`else
    // Statistics counters are not built in this configuration.
`endif

endmodule

`default_nettype wire

// File: tb/tb_udp_tx_scheduler.sv
// ============================================================================
// tb_udp_tx_scheduler : directed stimulus, cycle-level reference model plus literal checks
// Rev 1.0
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_udp_tx_scheduler;

    localparam int PKT_WORDS     = 98;
    localparam int FIFO_AW       = 12;
    localparam int GAP_CYCLES    = 16;
    localparam int START_TIMEOUT = 64;
    localparam int GAP_LEN       = (GAP_CYCLES == 0) ? 1 : GAP_CYCLES;

    logic               clk = 1'b0;
    logic               rst_n = 1'b0;
    logic               sched_en = 1'b0;
    logic               tx_active = 1'b0;
    logic [FIFO_AW-1:0] fifo_count = '0;
    logic               send_start;
    logic               sched_busy;
    logic               timeout_err;
    logic [31:0]        pkt_sent;
`ifdef UDP_SCHED_STATS_EN
    logic [31:0]        stall_cycles;
    logic [15:0]        timeout_cnt;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    always #4 clk = ~clk;

    udp_tx_scheduler #(
        .PKT_WORDS     (PKT_WORDS),
        .FIFO_AW       (FIFO_AW),
        .GAP_CYCLES    (GAP_CYCLES),
        .START_TIMEOUT (START_TIMEOUT)
    ) dut (
        .GMII_GTXCLK (clk),
        .rst_n       (rst_n),
        .sched_en    (sched_en),
        .fifo_count  (fifo_count),
        .tx_active   (tx_active),
        .send_start  (send_start),
        .sched_busy  (sched_busy),
        .timeout_err (timeout_err),
        .pkt_sent    (pkt_sent)
`ifdef UDP_SCHED_STATS_EN
        ,
        .stall_cycles (stall_cycles),
        .timeout_cnt  (timeout_cnt)
`endif
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: a packet goes start -> wait for fresh TXEN rise (or give up)
    // -> in flight until TXEN falls -> idle gap -> armed again if still enabled.
    typedef struct packed {
        logic [31:0] wait_left;
        logic [31:0] gap_left;
        logic [31:0] pkts;
        logic [31:0] stall;
        logic [15:0] tos;
        logic        in_pkt;
        logic        armed;
        logic        start;
        logic        err;
        logic        ptx;
        logic        pen;
    } model_t;

    model_t m;

    function automatic model_t step(input model_t c, input logic en, input logic tx,
                                    input logic [FIFO_AW-1:0] fifo);
        model_t n;
        logic   rise;
        logic   fall;
        n     = c;
        rise  = tx & ~c.ptx;
        fall  = ~tx & c.ptx;
        n.ptx = tx;
        n.pen = en;
        if (en && !c.pen) n.err = 1'b0;
        n.start = 1'b0;
        if (c.start) begin
            n.wait_left = 32'(START_TIMEOUT);
        end else if (c.wait_left != 0) begin
            if (rise) begin
                n.wait_left = 0;
                n.in_pkt    = 1'b1;
            end else begin
                n.wait_left = c.wait_left - 1;
                if (n.wait_left == 0) begin
                    n.err      = 1'b1;
                    n.gap_left = 32'(GAP_LEN);
                    if (c.tos != 16'hFFFF) n.tos = c.tos + 16'd1;
                end
            end
        end else if (c.in_pkt) begin
            if (fall) begin
                n.in_pkt   = 1'b0;
                n.pkts     = c.pkts + 1;
                n.gap_left = 32'(GAP_LEN);
            end
        end else if (c.gap_left != 0) begin
            n.gap_left = c.gap_left - 1;
            if (n.gap_left == 0) n.armed = en;
        end else if (c.armed) begin
            if (!en) begin
                n.armed = 1'b0;
            end else if (32'(fifo) >= 32'(PKT_WORDS)) begin
                n.armed = 1'b0;
                n.start = 1'b1;
            end else begin
                n.stall = c.stall + 1;
            end
        end else if (en) begin
            n.armed = 1'b1;
        end
        return n;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) m <= '0;
        else        m <= step(m, sched_en, tx_active, fifo_count);
    end

    always @(negedge clk) begin
        if (rst_n) begin
            check("mdl_send_start", 32'(send_start), 32'(m.start));
            check("mdl_sched_busy", 32'(sched_busy),
                  32'(m.start | (m.wait_left != 0) | m.in_pkt | (m.gap_left != 0) | m.armed));
            check("mdl_timeout_err", 32'(timeout_err), 32'(m.err));
            check("mdl_pkt_sent", pkt_sent, m.pkts);
`ifdef UDP_SCHED_STATS_EN
            check("mdl_stall_cycles", stall_cycles, m.stall);
            check("mdl_timeout_cnt", 32'(timeout_cnt), 32'(m.tos));
`endif
        end
    end

    task automatic count_starts(input int cyc, output int cnt);
        cnt = 0;
        repeat (cyc) begin
            @(posedge clk);
            @(negedge clk);
            if (send_start) cnt++;
        end
    endtask

    // Clock edges from the current negedge until send_start is seen; -1 on expiry.
    task automatic wait_start(input int max_cyc, output int n);
        n = 0;
        while (n < max_cyc) begin
            @(posedge clk);
            n++;
            @(negedge clk);
            if (send_start) return;
        end
        n_checks++;
        n_fail++;
        $display("FAIL wait_start: no send_start within %0d clk", max_cyc);
        n = -1;
    endtask

    task automatic wait_err(input int max_cyc, output int n);
        n = 0;
        while (n < max_cyc) begin
            @(posedge clk);
            n++;
            @(negedge clk);
            if (timeout_err) return;
        end
        n_checks++;
        n_fail++;
        $display("FAIL wait_err: no timeout_err within %0d clk", max_cyc);
        n = -1;
    endtask

    initial begin
        int n;
        int cnt;

        #1;
        check("rst_send_start", 32'(send_start), 32'd0);
        check("rst_sched_busy", 32'(sched_busy), 32'd0);
        check("rst_timeout_err", 32'(timeout_err), 32'd0);
        check("rst_pkt_sent", pkt_sent, 32'd0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;

        // One word short of a packet: armed but never starts.
        sched_en   = 1'b1;
        fifo_count = 12'd97;
        count_starts(10, cnt);
        check("t1_below_thresh_starts", 32'(cnt), 32'd0);
        check("t1_armed_busy", 32'(sched_busy), 32'd1);
        fifo_count = 12'd98;
        @(posedge clk);
        @(negedge clk);
        check("t1_start_after_1clk", 32'(send_start), 32'd1);
        @(posedge clk);
        @(negedge clk);
        check("t1_pulse_one_cycle", 32'(send_start), 32'd0);

        // 150-cycle packet; restart GAP_CYCLES+1 edges after the edge that sees TXEN low.
        tx_active  = 1'b1;
        fifo_count = 12'd500;
        repeat (150) @(negedge clk);
        tx_active = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check("t2_pkt_sent_1", pkt_sent, 32'd1);
        wait_start(100, n);
        check("t2_gap_to_start", 32'(n), 32'(GAP_CYCLES + 1));

        // No TXEN: 64 waiting cycles follow the start cycle, so the flag shows 65 edges later.
        wait_err(200, n);
        check("t3_timeout_edges", 32'(n), 32'(START_TIMEOUT + 1));
        check("t3_busy_in_gap", 32'(sched_busy), 32'd1);
        wait_start(100, n);
        check("t3_retry_start", 32'(n), 32'(GAP_CYCLES + 1));

        // Disable mid-packet: packet still completes, then the scheduler parks.
        @(posedge clk);
        @(negedge clk);
        tx_active = 1'b1;
        repeat (10) @(negedge clk);
        sched_en = 1'b0;
        check("t4_busy_not_interrupted", 32'(sched_busy), 32'd1);
        repeat (10) @(negedge clk);
        tx_active = 1'b0;
        count_starts(40, cnt);
        check("t4_no_starts_disabled", 32'(cnt), 32'd0);
        check("t4_pkt_sent_2", pkt_sent, 32'd2);
        check("t4_idle", 32'(sched_busy), 32'd0);
        check("t4_err_sticky", 32'(timeout_err), 32'd1);
        sched_en = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("t4_err_cleared_by_en_rise", 32'(timeout_err), 32'd0);

        // Asynchronous reset in the middle of a packet.
        wait_start(10, n);
        @(posedge clk);
        @(negedge clk);
        tx_active = 1'b1;
        repeat (5) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("t5_async_send_start", 32'(send_start), 32'd0);
        check("t5_async_busy", 32'(sched_busy), 32'd0);
        check("t5_async_err", 32'(timeout_err), 32'd0);
        check("t5_async_pkt_sent", pkt_sent, 32'd0);
        @(negedge clk);
        sched_en   = 1'b0;
        tx_active  = 1'b0;
        fifo_count = 12'd500;
        rst_n      = 1'b1;
        count_starts(20, cnt);
        check("t5_no_start_after_rst", 32'(cnt), 32'd0);
        check("t5_idle_after_rst", 32'(sched_busy), 32'd0);

        // 40 stalled cycles in ARM, then three back-to-back timeouts.
        sched_en   = 1'b1;
        fifo_count = 12'd0;
        @(posedge clk);
        repeat (40) @(posedge clk);
        @(negedge clk);
        check("t6_armed_busy", 32'(sched_busy), 32'd1);
`ifdef UDP_SCHED_STATS_EN
        check("t6_stall_40", stall_cycles, 32'd40);
`endif
        fifo_count = 12'd98;
        wait_start(5, n);
        check("t6_first_start", 32'(n), 32'd1);
        wait_start(200, n);
        check("t6_start_spacing_a", 32'(n), 32'(START_TIMEOUT + GAP_CYCLES + 2));
        wait_start(200, n);
        check("t6_start_spacing_b", 32'(n), 32'(START_TIMEOUT + GAP_CYCLES + 2));
        repeat (70) @(negedge clk);
        check("t6_err_after_timeouts", 32'(timeout_err), 32'd1);
`ifdef UDP_SCHED_STATS_EN
        check("t6_timeout_cnt_3", 32'(timeout_cnt), 32'd3);
`endif
        sched_en = 1'b0;
        repeat (30) @(negedge clk);
        check("t6_idle_at_end", 32'(sched_busy), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
